// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with count, programmable flags and std/FWFT read
module fifo_sync_prog #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [FIFO_WIDTH-1:0]         d_in,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         d_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Reject illegal configurations at elaboration.
    if ((FIFO_DEPTH < 2) || ((1 << ADDR_W) != FIFO_DEPTH)) begin : g_bad_depth
        $error("fifo_sync_prog: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_bad_af
        $error("fifo_sync_prog: AF_THRESH must be in 1..FIFO_DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_bad_ae
        $error("fifo_sync_prog: AE_THRESH must be in 0..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  ovf_q, udf_q;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  wr_acc, rd_acc;

    // Acceptance from pre-edge state; a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        wr_acc   = wr_en && (!full_q || rd_en);
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_q] <= d_in;
        end
    end

    // Pointers, occupancy, flags registered from next count, and rejection pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= CNT_W'(AF_THRESH));
            ae_q     <= (count_d <= CNT_W'(AE_THRESH));
            ovf_q    <= wr_en && !wr_acc;
            udf_q    <= rd_en && !rd_acc;
        end
    end

    // Standard-mode output register: loads the head word on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr_q];
        end
    end

    assign d_out        = FWFT ? mem[rd_ptr_q] : dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - directed self-checking bench for fifo_sync_prog (standard and FWFT)
module tb_fifo_sync_prog;

    logic       clk;
    logic       rst;
    logic       wr_en, rd_en;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       full, empty, af, ae, ovf, udf;
    logic [3:0] count;

    logic       f_wr_en, f_rd_en;
    logic [7:0] f_d_in;
    logic [7:0] f_d_out;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] f_count;

    int checks = 0;
    int passed = 0;

    fifo_sync_prog #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en), .d_out(d_out),
        .full(full), .empty(empty), .almost_full(af), .almost_empty(ae), .count(count),
        .overflow(ovf), .underflow(udf)
    );

    fifo_sync_prog #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .d_in(f_d_in), .rd_en(f_rd_en), .d_out(f_d_out),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if ({empty, ae, full, af, ovf, udf} !== 6'b110000)
            $display("FAIL reset_flags got=%b exp=110000", {empty, ae, full, af, ovf, udf});
        else passed++;
        checks++;
        if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count);
        else passed++;
        checks++;
        if (d_out !== 8'h00) $display("FAIL reset_dout got=%h exp=00", d_out);
        else passed++;
        checks++;
        if (f_empty !== 1'b1 || f_count !== 4'd0)
            $display("FAIL reset_fwft got empty=%b count=%0d exp empty=1 count=0", f_empty, f_count);
        else passed++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            d_in  = 8'(i);
            cyc();
            checks++;
            if (count !== 4'(i) || ae !== (i <= 1) || af !== (i >= 6) || full !== (i == 8) || empty !== 1'b0)
                $display("FAIL fill_%0d got count=%0d ae=%b af=%b full=%b empty=%b", i, count, ae, af, full, empty);
            else passed++;
        end
        d_in = 8'hAA;
        cyc();
        wr_en = 1'b0;
        checks++;
        if (ovf !== 1'b1 || count !== 4'd8 || full !== 1'b1)
            $display("FAIL fill_overflow got ovf=%b count=%0d full=%b exp 1 8 1", ovf, count, full);
        else passed++;
        cyc();
        checks++;
        if (ovf !== 1'b0) $display("FAIL fill_ovf_pulse got=%b exp=0", ovf);
        else passed++;
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            cyc();
            checks++;
            if (d_out !== 8'(i)) $display("FAIL drain_%0d got=%h exp=%h", i, d_out, 8'(i));
            else passed++;
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || ae !== 1'b1)
            $display("FAIL drain_end got empty=%b count=%0d ae=%b", empty, count, ae);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_w [8];
        exp_w = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; d_in = 8'(i); cyc();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; cyc();
            checks++;
            if (d_out !== 8'(i)) $display("FAIL wrap_rd_%0d got=%h exp=%h", i, d_out, 8'(i));
            else passed++;
        end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; d_in = 8'h10 + 8'(i); cyc();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; cyc();
            checks++;
            if (d_out !== exp_w[i]) $display("FAIL wrap_out_%0d got=%h exp=%h", i, d_out, exp_w[i]);
            else passed++;
        end
        rd_en = 1'b0;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) $display("FAIL wrap_end got count=%0d empty=%b", count, empty);
        else passed++;
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; d_in = 8'h20 + 8'(i); cyc();
        end
        d_in = 8'h24; rd_en = 1'b1; cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 4'd3 || d_out !== 8'h21) $display("FAIL simul_mid got count=%0d dout=%h exp 3 21", count, d_out);
        else passed++;
        for (int i = 2; i <= 4; i++) begin
            rd_en = 1'b1; cyc();
            checks++;
            if (d_out !== 8'h20 + 8'(i)) $display("FAIL simul_drain_%0d got=%h exp=%h", i, d_out, 8'h20 + 8'(i));
            else passed++;
        end
        wr_en = 1'b1; rd_en = 1'b1; d_in = 8'h05; cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 4'd1 || udf !== 1'b1 || d_out !== 8'h24)
            $display("FAIL simul_empty got count=%0d udf=%b dout=%h exp 1 1 24", count, udf, d_out);
        else passed++;
        cyc();
        checks++;
        if (udf !== 1'b0) $display("FAIL simul_udf_pulse got=%b exp=0", udf);
        else passed++;
        rd_en = 1'b1; cyc(); rd_en = 1'b0;
        checks++;
        if (d_out !== 8'h05) $display("FAIL simul_read5 got=%h exp=05", d_out);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; d_in = 8'h30 + 8'(i); cyc();
        end
        d_in = 8'h99; rd_en = 1'b1; cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 4'd8 || d_out !== 8'h30 || full !== 1'b1 || ovf !== 1'b0)
            $display("FAIL simul_full got count=%0d dout=%h full=%b ovf=%b", count, d_out, full, ovf);
        else passed++;
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1; cyc();
            checks++;
            if (d_out !== ((i == 8) ? 8'h99 : 8'h30 + 8'(i)))
                $display("FAIL simul_fdrain_%0d got=%h", i, d_out);
            else passed++;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; d_in = 8'h02; cyc();
        d_in = 8'h05; cyc();
        wr_en = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || ae !== 1'b1)
            $display("FAIL rstmid_state got count=%0d empty=%b ae=%b", count, empty, ae);
        else passed++;
        rd_en = 1'b1; cyc(); rd_en = 1'b0;
        checks++;
        if (udf !== 1'b1 || d_out !== 8'h00) $display("FAIL rstmid_read got udf=%b dout=%h exp 1 00", udf, d_out);
        else passed++;
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1; f_d_in = 8'h3C; cyc();
        f_wr_en = 1'b0;
        checks++;
        if (f_empty !== 1'b0 || f_d_out !== 8'h3C)
            $display("FAIL fwft_first got empty=%b dout=%h exp 0 3c", f_empty, f_d_out);
        else passed++;
        f_wr_en = 1'b1; f_d_in = 8'h3D; cyc();
        f_wr_en = 1'b0;
        checks++;
        if (f_d_out !== 8'h3C || f_count !== 4'd2) $display("FAIL fwft_hold got dout=%h count=%0d", f_d_out, f_count);
        else passed++;
        f_rd_en = 1'b1; cyc(); f_rd_en = 1'b0;
        checks++;
        if (f_d_out !== 8'h3D || f_count !== 4'd1) $display("FAIL fwft_pop got dout=%h count=%0d", f_d_out, f_count);
        else passed++;
        f_rd_en = 1'b1; cyc(); f_rd_en = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_count !== 4'd0) $display("FAIL fwft_empty got empty=%b count=%0d", f_empty, f_count);
        else passed++;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; d_in = 8'h00;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_d_in = 8'h00;
        test_reset();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_fwft();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
